// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the cache memory port.
// It also has a watchdog that ends any transaction the cache never acknowledges.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_wdata,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_wdata,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_wdata,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nxt;
   logic          last_grant;
   logic [CW-1:0] wait_cnt;
   logic          take;
   logic          pick;
   logic          done_ok;
   logic          done_to;

   assign s_valid = (state == BUSY);

   // Arbitration, completion and watchdog decisions. The pick is the master
   // index, and on a tie it goes to the master that was not granted last.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      pick      = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      m0_ready  = 1'b0;
      m1_ready  = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      case (state)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               take      = 1'b1;
               pick      = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            done_ok = s_ready;
            done_to = !s_ready && (wait_cnt == CW'(TIMEOUT - 1));
            if (done_ok || done_to) begin
               state_nxt = IDLE;
               m0_ready  = grant[0];
               m1_ready  = grant[1];
               if (done_ok) begin
                  m0_rdata = grant[0] ? s_rdata : '0;
                  m1_rdata = grant[1] ? s_rdata : '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus the captured request, owner and watchdog counter.
   // The counter stops on the timeout cycle itself, so it never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         wait_cnt    <= '0;
         grant       <= 2'b00;
         s_addr      <= '0;
         s_wstrb     <= '0;
         s_wdata     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take) begin
            grant      <= pick ? 2'b10 : 2'b01;
            last_grant <= pick;
            s_addr     <= pick ? m1_addr  : m0_addr;
            s_wstrb    <= pick ? m1_wstrb : m0_wstrb;
            s_wdata    <= pick ? m1_wdata : m0_wdata;
            wait_cnt   <= '0;
         end else if (state == BUSY) begin
            if (done_ok || done_to) begin
               grant <= 2'b00;
            end
            if (done_to) begin
               timeout_err <= 1'b1;
            end
            if (!s_ready && !done_to) begin
               wait_cnt <= wait_cnt + CW'(1);
            end
         end
      end
   end

endmodule
